cv32e40p_sleep_unit_mc: RTL and testbench

//  Multi-domain sleep/clock-gating controller: successor to the single-gate core sleep unit.

---
 rtl/cv32e40p_pkg.sv | 13 +
 rtl/cv32e40p_clock_gate.sv | 18 +
 rtl/cv32e40p_sleep_unit_mc.sv | 145 ++++++++++++++
 tb/tb_cv32e40p_sleep_unit_mc.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the multi-domain sleep unit.
// State encoding for the sleep/clock-gating FSM.
package cv32e40p_pkg;

   typedef enum logic [2:0] {
      SLP_OFF,
      SLP_RUN,
      SLP_HYST,
      SLP_SLEEP,
      SLP_WAKE
   } sleep_state_e;

endpackage

// File: rtl/cv32e40p_clock_gate.sv
// Latch-based clock gate: the enable is captured while clk is low,
// so the gated clock never shows a truncated high phase.
module cv32e40p_clock_gate (
   input  logic clk,
   input  logic en,
   input  logic scan_en,
   output logic clk_gated
);

   logic en_q;

   always_latch begin
      if (!clk) en_q <= en | scan_en;
   end

   assign clk_gated = clk & en_q;

endmodule

// File: rtl/cv32e40p_sleep_unit_mc.sv
// Multi-domain sleep controller: idle hysteresis before sleep,
// per-domain auto-gating in RUN and a counted wake-up sequence.
module cv32e40p_sleep_unit_mc
   import cv32e40p_pkg::*;
#(
   parameter int NUM_DOMAINS = 2,
   parameter int IDLE_HYST   = 4,
   parameter int WAKE_DLY    = 2
) (
   input  logic                   clk_ungated_i,
   input  logic                   rst_n,
   input  logic                   scan_cg_en_i,
   input  logic                   fetch_enable_i,
   output logic                   fetch_enable_o,
   input  logic                   sleep_req_i,
   input  logic                   wake_i,
   input  logic [NUM_DOMAINS-1:0] busy_i,
   output logic [NUM_DOMAINS-1:0] clk_gated_o,
   output logic                   core_sleep_o,
   output logic                   wake_done_o
);

   localparam int HW = (IDLE_HYST > 0) ? $clog2(IDLE_HYST + 1) : 1;
   localparam int WW = $clog2(WAKE_DLY + 1);
   localparam logic [HW-1:0] HYST_MAX = HW'(IDLE_HYST);
   localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_DLY);

   sleep_state_e state_q, state_d;

   logic                   fe_q;
   logic [NUM_DOMAINS-1:0] busy_q;
   logic [HW-1:0]          idle_cnt [NUM_DOMAINS];
   logic [HW-1:0]          hyst_cnt;
   logic [WW-1:0]          wake_cnt;
   logic [NUM_DOMAINS-1:0] run_en;
   logic [NUM_DOMAINS-1:0] en;
   logic                   any_busy;

   assign fetch_enable_o = fe_q;
   assign any_busy       = |busy_i;

   // Domain 0 always runs in RUN; others stay open through the idle window.
   for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_run_en
      assign run_en[d] = 1'(d == 0) | busy_i[d] | busy_q[d] |
                         (idle_cnt[d] < HYST_MAX);
   end

   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) state_q <= SLP_OFF;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SLP_OFF:
            if (fe_q) state_d = SLP_RUN;
         SLP_RUN:
            if (sleep_req_i && !wake_i && !any_busy) state_d = SLP_HYST;
         SLP_HYST:
            if (wake_i || !sleep_req_i || any_busy) state_d = SLP_RUN;
            else if (hyst_cnt == HYST_MAX)        state_d = SLP_SLEEP;
         SLP_SLEEP:
            if (wake_i) state_d = SLP_WAKE;
         SLP_WAKE:
            if (wake_cnt == WAKE_MAX) state_d = SLP_RUN;
         default:
            state_d = SLP_OFF;
      endcase
   end

   always_comb begin
      en           = '0;
      core_sleep_o = 1'b0;
      wake_done_o  = 1'b0;
      case (state_q)
         SLP_RUN:  en = run_en;
         SLP_HYST: en = '1;
         SLP_SLEEP: begin
            en           = {NUM_DOMAINS{wake_i}};
            core_sleep_o = 1'b1;
         end
         SLP_WAKE: begin
            en          = '1;
            wake_done_o = (wake_cnt == WAKE_MAX);
         end
         default: en = '0;
      endcase
   end

   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) begin
         fe_q     <= 1'b0;
         busy_q   <= '0;
         hyst_cnt <= '0;
         wake_cnt <= '0;
         for (int d = 0; d < NUM_DOMAINS; d++) idle_cnt[d] <= '0;
      end else begin
         fe_q <= fetch_enable_i | fe_q;
         if (state_q != SLP_SLEEP) busy_q <= busy_i;
         case (state_q)
            SLP_RUN: begin
               hyst_cnt <= '0;
               for (int d = 0; d < NUM_DOMAINS; d++) begin
                  if (busy_i[d])                   idle_cnt[d] <= '0;
                  else if (idle_cnt[d] < HYST_MAX) idle_cnt[d] <= idle_cnt[d] + 1'b1;
               end
            end
            SLP_HYST:
               if (hyst_cnt < HYST_MAX) hyst_cnt <= hyst_cnt + 1'b1;
            SLP_SLEEP:
               if (wake_i) wake_cnt <= WW'(1);
            SLP_WAKE:
               if (wake_cnt == WAKE_MAX) begin
                  wake_cnt <= '0;
                  for (int d = 0; d < NUM_DOMAINS; d++) idle_cnt[d] <= '0;
               end else begin
                  wake_cnt <= wake_cnt + 1'b1;
               end
            default: ;
         endcase
      end
   end

   for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_gate
      cv32e40p_clock_gate u_cg (
         .clk       (clk_ungated_i),
         .en        (en[d]),
         .scan_en   (scan_cg_en_i),
         .clk_gated (clk_gated_o[d])
      );
   end

`ifdef CV32E40P_ASSERT_ON
   a_sleep_gated: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
      core_sleep_o && !wake_i |-> en == '0);
   a_done_pulse: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
      wake_done_o |=> !wake_done_o);
   a_off_gated: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
      state_q == SLP_OFF |-> en == '0);
   a_sleep_idle: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
      state_q == SLP_SLEEP |-> busy_i == '0);
`endif

endmodule

// File: tb/tb_cv32e40p_sleep_unit_mc.sv
// Bench for the multi-domain sleep unit: vector table plus
// a hand-written reset-during-wake sequence.
module tb_cv32e40p_sleep_unit_mc;

   logic       clk;
   logic       rst_n;
   logic       scan;
   logic       fe_i;
   logic       fe_o;
   logic       sreq;
   logic       wake;
   logic [1:0] busy;
   logic [1:0] gclk;
   logic       csleep;
   logic       wdone;

   typedef struct packed {
      logic       rst;
      logic       fe;
      logic       sr;
      logic       wk;
      logic [1:0] busy;
      logic       scan;
      logic [4:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [4:0] sb[$];
   int         n_tests;
   int         n_fail;

   cv32e40p_sleep_unit_mc #(
      .NUM_DOMAINS (2),
      .IDLE_HYST   (4),
      .WAKE_DLY    (2)
   ) dut (
      .clk_ungated_i  (clk),
      .rst_n          (rst_n),
      .scan_cg_en_i   (scan),
      .fetch_enable_i (fe_i),
      .fetch_enable_o (fe_o),
      .sleep_req_i    (sreq),
      .wake_i         (wake),
      .busy_i         (busy),
      .clk_gated_o    (gclk),
      .core_sleep_o   (csleep),
      .wake_done_o    (wdone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // exp = {core_sleep, wake_done, fetch_enable_o, gate[1:0]}
   task automatic add(input int r, input int f, input int s, input int w,
                      input int b, input int sc, input int cs, input int wd,
                      input int fo, input int g);
      vec_t v;
      v.rst  = 1'(r);
      v.fe   = 1'(f);
      v.sr   = 1'(s);
      v.wk   = 1'(w);
      v.busy = 2'(b);
      v.scan = 1'(sc);
      v.exp  = {1'(cs), 1'(wd), 1'(fo), 2'(g)};
      vecs.push_back(v);
   endtask

   task automatic addn(input int n, input int r, input int f, input int s,
                       input int w, input int b, input int sc, input int cs,
                       input int wd, input int fo, input int g);
      for (int k = 0; k < n; k++) add(r, f, s, w, b, sc, cs, wd, fo, g);
   endtask

   // Outputs sampled mid-cycle; gates sampled just after the closing edge.
   task automatic run_vec(input int i);
      vec_t       v;
      logic [2:0] o;
      logic [4:0] e;
      v     = vecs[i];
      rst_n = v.rst;
      fe_i  = v.fe;
      sreq  = v.sr;
      wake  = v.wk;
      busy  = v.busy;
      scan  = v.scan;
      sb.push_back(v.exp);
      @(negedge clk);
      o = {csleep, wdone, fe_o};
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d", i), {3'b000, o, gclk}, {3'b000, e});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      scan    = 1'b0;
      fe_i    = 1'b0;
      sreq    = 1'b0;
      wake    = 1'b0;
      busy    = 2'b00;

      //    n  rst fe sr wk busy scan  cs wd fo g
      addn(2,  0,  0, 0, 0, 0,   0,    0, 0, 0, 0);
      addn(10, 1,  0, 0, 0, 0,   0,    0, 0, 0, 0);
      add (    1,  1, 0, 0, 0,   0,    0, 0, 0, 0);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 0);
      addn(4,  1,  0, 0, 0, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 1);
      addn(2,  1,  0, 0, 0, 2,   0,    0, 0, 1, 3);
      addn(4,  1,  0, 0, 0, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 1);
      add (    1,  0, 0, 0, 2,   0,    0, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 1, 0, 0,   0,    0, 0, 1, 3);
      addn(5,  1,  0, 1, 0, 0,   0,    0, 0, 1, 3);
      addn(2,  1,  0, 1, 0, 0,   0,    1, 0, 1, 0);
      add (    1,  0, 1, 0, 0,   1,    1, 0, 1, 3);
      add (    1,  0, 1, 0, 0,   0,    1, 0, 1, 0);
      add (    1,  0, 0, 1, 0,   0,    1, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 1, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 3);
      addn(3,  1,  0, 1, 0, 0,   0,    0, 0, 1, 3);
      addn(2,  1,  0, 1, 1, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 1);
      add (    1,  0, 1, 0, 0,   0,    0, 0, 1, 1);
      addn(2,  1,  0, 1, 0, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 1, 0, 1,   0,    0, 0, 1, 3);
      add (    1,  0, 0, 0, 1,   0,    0, 0, 1, 1);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 1);
      add (    1,  0, 1, 0, 0,   0,    0, 0, 1, 1);
      add (    1,  0, 1, 0, 0,   0,    0, 0, 1, 3);
      addn(2,  0,  0, 1, 0, 0,   0,    0, 0, 0, 0);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 0, 0);
      add (    1,  1, 0, 0, 0,   0,    0, 0, 0, 0);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 0);
      add (    1,  0, 1, 0, 0,   0,    0, 0, 1, 3);
      addn(5,  1,  0, 1, 0, 0,   0,    0, 0, 1, 3);
      add (    1,  0, 1, 0, 0,   0,    1, 0, 1, 0);
      add (    1,  0, 0, 1, 0,   0,    1, 0, 1, 3);
      add (    1,  0, 0, 0, 0,   0,    0, 0, 1, 3);

      @(posedge clk);
      #1;
      foreach (vecs[i]) run_vec(i);

      // Now in WAKE with the counter at its last step.
      fe_i = 1'b0;
      sreq = 1'b0;
      wake = 1'b0;
      busy = 2'b00;
      scan = 1'b0;
      #2;
      chk("wake_done_hi", {7'd0, wdone}, 8'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_in_wake", {5'd0, csleep, wdone, fe_o}, 8'd0);
      @(negedge clk);
      #1;
      chk("gate_flat_lo", {6'd0, gclk}, 8'd0);
      @(posedge clk);
      #1;
      chk("gate_flat_hi", {6'd0, gclk}, 8'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("off_after_rst", {5'd0, fe_o, gclk}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
